// File: rtl/mem_arb_pkg.sv
// Shared SAP-2 definitions: owner and FSM state encodings, default RAM geometry.
package sap2_defs;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the CPU memory path, the program loader, the arbiter and the RAM port.
// MEM_ARB_LOCK_EN adds the ldr_lock input.
interface mem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 12
);
    // Four-phase handshake: a requester raises req with its command stable,
    // the arbiter raises ack once the RAM op is done, req falls, then ack falls.
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic          ldr_lock;
`endif

    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic          ram_ce;
    logic [DW-1:0] ram_q;

    logic [1:0]    owner;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
`ifdef MEM_ARB_LOCK_EN
        input  ldr_lock,
`endif
        output ram_a, ram_d, ram_we, ram_ce,
        input  ram_q,
        output owner
    );

    // Requester / RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
`ifdef MEM_ARB_LOCK_EN
        output ldr_lock,
`endif
        input  ram_a, ram_d, ram_we, ram_ce,
        output ram_q,
        input  owner
    );

endinterface

// File: rtl/mem_arb_rr_pick2.sv
// Combinational two-way round-robin picker; grant[0] = requester a, grant[1] = requester b.
module rr_pick2 (
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_b,
    input  logic       lock,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock) begin
            grant[1] = req_b;
        end else if (req_a && req_b) begin
            // On a tie the side not served last wins
            grant = last_b ? 2'b01 : 2'b10;
        end else begin
            grant = {req_b, req_a};
        end
    end

endmodule

// File: rtl/mem_arb.sv
// CPU / program-loader arbiter for the single 256x12 RAM port: IDLE -> ACCESS -> ACK per access.
// MEM_ARB_LOCK_EN adds ldr_lock, which locks the CPU out and always favours the loader.
module mem_arb
    import sap2_defs::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic   clk,
    input  logic   clr,
    mem_arb_if.slave bus,
    output state_t dbg_state
);

    state_t        state, state_nxt;
    owner_t        owner_q, owner_nxt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          last_ldr;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;
    logic          lock;
    logic [1:0]    grant;
    logic          owner_req;

`ifdef MEM_ARB_LOCK_EN
    assign lock = bus.ldr_lock;
`else
    assign lock = 1'b0;
`endif

    rr_pick2 u_pick (
        .req_a (bus.cpu_req),
        .req_b (bus.ldr_req),
        .last_b(last_ldr),
        .lock  (lock),
        .grant (grant)
    );

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            OWN_CPU: owner_req = bus.cpu_req;
            OWN_LDR: owner_req = bus.ldr_req;
            default: owner_req = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        case (state)
            ST_IDLE: begin
                if (grant[0]) begin
                    owner_nxt = OWN_CPU;
                    state_nxt = ST_ACCESS;
                end else if (grant[1]) begin
                    owner_nxt = OWN_LDR;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_ACK;
            ST_ACK: begin
                if (!owner_req) begin
                    owner_nxt = OWN_NONE;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                owner_nxt = OWN_NONE;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= ST_IDLE;
            owner_q     <= OWN_NONE;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            last_ldr    <= 1'b1;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            if (state == ST_IDLE && grant != 2'b00) begin
                // Reads latch zero write data so ram_d stays quiet
                if (grant[0]) begin
                    lat_we    <= bus.cpu_we;
                    lat_addr  <= bus.cpu_addr;
                    lat_wdata <= bus.cpu_we ? bus.cpu_wdata : '0;
                end else begin
                    lat_we    <= bus.ldr_we;
                    lat_addr  <= bus.ldr_addr;
                    lat_wdata <= bus.ldr_we ? bus.ldr_wdata : '0;
                end
            end
            if (state == ST_ACCESS) begin
                last_ldr <= (owner_q == OWN_LDR);
                if (!lat_we) begin
                    if (owner_q == OWN_LDR) ldr_rdata_q <= bus.ram_q;
                    else                    cpu_rdata_q <= bus.ram_q;
                end
            end
        end
    end

    // Strobes decode straight from state so clr kills a write in flight
    assign bus.ram_a     = lat_addr;
    assign bus.ram_d     = lat_wdata;
    assign bus.ram_we    = (state == ST_ACCESS) &&  lat_we;
    assign bus.ram_ce    = (state == ST_ACCESS) && !lat_we;
    assign bus.cpu_ack   = (state == ST_ACK) && (owner_q == OWN_CPU);
    assign bus.ldr_ack   = (state == ST_ACK) && (owner_q == OWN_LDR);
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.owner     = owner_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: table of single-requester accesses plus tie, drop, clr and lock sequences.
module tb_mem_arb;
  import sap2_defs::*;

  logic   clk;
  logic   clr;
  state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_rd[2];
  logic [11:0] mem[256];

  mem_arb_if #(.AW(8), .DW(12)) bus ();

  mem_arb #(.AW(8), .DW(12)) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: combinational read, write at the rising edge
  assign bus.ram_q = mem[bus.ram_a];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Both acks must never be high together
  always @(negedge clk) begin
    if (!clr) chk("ack_exclusive", {31'd0, bus.cpu_ack && bus.ldr_ack}, 32'd0);
  end

  task automatic set_req(input bit who, input bit req, input bit we,
                         input logic [7:0] addr, input logic [11:0] wdata);
    if (who) begin
      bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  // One complete single-requester access, starting at a falling edge in IDLE
  task automatic do_access(input bit who, input bit we, input logic [7:0] addr,
                           input logic [11:0] wdata, input logic [11:0] exp_rdata);
    logic [1:0] own;
    own = who ? 2'b10 : 2'b01;
    if (!we) exp_q.push_back(exp_rdata);
    set_req(who, 1'b1, we, addr, wdata);
    @(posedge clk); @(negedge clk);
    chk("acc_state", {30'd0, dbg_state}, {30'd0, ST_ACCESS});
    chk("acc_owner", {30'd0, bus.owner}, {30'd0, own});
    chk("acc_we", {31'd0, bus.ram_we}, {31'd0, we});
    chk("acc_ce", {31'd0, bus.ram_ce}, {31'd0, !we});
    chk("acc_a", {24'd0, bus.ram_a}, {24'd0, addr});
    chk("acc_d", {20'd0, bus.ram_d}, {20'd0, (we ? wdata : 12'h000)});
    if (!who) chk("acc_stall", {31'd0, bus.cpu_stall}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("ack_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, {30'd0, own});
    chk("ack_strobes", {30'd0, bus.ram_we, bus.ram_ce}, 32'd0);
    if (!who) chk("ack_stall", {31'd0, bus.cpu_stall}, 32'd0);
    if (!we) exp_rd[who] = exp_q.pop_front();
    chk("cpu_rdata", {20'd0, bus.cpu_rdata}, {20'd0, exp_rd[0]});
    chk("ldr_rdata", {20'd0, bus.ldr_rdata}, {20'd0, exp_rd[1]});
    @(posedge clk); @(negedge clk);
    chk("ack_hold", {30'd0, bus.ldr_ack, bus.cpu_ack}, {30'd0, own});
    set_req(who, 1'b0, we, addr, wdata);
    @(posedge clk); @(negedge clk);
    chk("rel_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, 32'd0);
    chk("rel_owner", {30'd0, bus.owner}, {30'd0, OWN_NONE});
    chk("rel_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    exp_rd[0] = 12'h000;
    exp_rd[1] = 12'h000;
    @(negedge clk);
  endtask

  typedef struct {
    bit          who;
    bit          we;
    logic [7:0]  addr;
    logic [11:0] wdata;
    logic [11:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h10, 12'hABC, 12'h000};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 12'h000, 12'hABC};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 12'h5A5, 12'h000};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 12'h000, 12'h5A5};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 12'hFFF, 12'h000};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 12'h000, 12'hFFF};
    vecs[6] = '{1'b0, 1'b0, 8'h10, 12'h000, 12'hABC};
    vecs[7] = '{1'b1, 1'b1, 8'h80, 12'h001, 12'h000};
    vecs[8] = '{1'b0, 1'b0, 8'h80, 12'h000, 12'h001};

    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    exp_rd[0] = 12'h000;
    exp_rd[1] = 12'h000;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
`ifdef MEM_ARB_LOCK_EN
    bus.ldr_lock = 1'b0;
`endif
    clr = 1'b1;
    #2;
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("rst_owner", {30'd0, bus.owner}, 32'd0);
    chk("rst_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, 32'd0);
    chk("rst_strobes", {30'd0, bus.ram_we, bus.ram_ce}, 32'd0);
    chk("rst_a_d", {12'd0, bus.ram_a, bus.ram_d}, 32'd0);
    chk("rst_rdata", {8'd0, bus.cpu_rdata, bus.ldr_rdata}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Tie twice in a row after reset: CPU first, then loader
    pulse_clr();
    set_req(1'b0, 1'b1, 1'b0, 8'h10, 12'h000);
    set_req(1'b1, 1'b1, 1'b0, 8'hFF, 12'h000);
    @(posedge clk); @(negedge clk);
    chk("tie1_owner", {30'd0, bus.owner}, {30'd0, OWN_CPU});
    @(posedge clk); @(negedge clk);
    chk("tie1_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, 32'd1);
    chk("tie1_rdata", {20'd0, bus.cpu_rdata}, 32'hABC);
    bus.cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("tie_gap_owner", {30'd0, bus.owner}, {30'd0, OWN_NONE});
    bus.cpu_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("tie2_owner", {30'd0, bus.owner}, {30'd0, OWN_LDR});
    @(posedge clk); @(negedge clk);
    chk("tie2_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, 32'd2);
    chk("tie2_rdata", {20'd0, bus.ldr_rdata}, 32'h5A5);
    chk("tie2_cpu_rdata", {20'd0, bus.cpu_rdata}, 32'hABC);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("tie_end_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    exp_rd[0] = 12'hABC;
    exp_rd[1] = 12'h5A5;

    // CPU write whose req drops during ACCESS still lands
    set_req(1'b0, 1'b1, 1'b1, 8'h20, 12'h123);
    @(posedge clk); @(negedge clk);
    chk("drop_we", {31'd0, bus.ram_we}, 32'd1);
    chk("drop_a_d", {12'd0, bus.ram_a, bus.ram_d}, {12'd0, 8'h20, 12'h123});
    bus.cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("drop_ack", {31'd0, bus.cpu_ack}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("drop_ack_gone", {31'd0, bus.cpu_ack}, 32'd0);
    chk("drop_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    do_access(1'b1, 1'b0, 8'h20, 12'h000, 12'h123);

    // clr in the middle of ACCESS
    set_req(1'b0, 1'b1, 1'b1, 8'h30, 12'h777);
    @(posedge clk); @(negedge clk);
    chk("clr_pre_we", {31'd0, bus.ram_we}, 32'd1);
    #1 clr = 1'b1;
    #1;
    chk("clr_we", {30'd0, bus.ram_we, bus.ram_ce}, 32'd0);
    chk("clr_owner", {30'd0, bus.owner}, 32'd0);
    chk("clr_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("clr_a_d", {12'd0, bus.ram_a, bus.ram_d}, 32'd0);
    chk("clr_rdata", {8'd0, bus.cpu_rdata, bus.ldr_rdata}, 32'd0);
    clr = 1'b0;
    exp_rd[0] = 12'h000;
    exp_rd[1] = 12'h000;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 8'h30, 12'h000);
    set_req(1'b1, 1'b1, 1'b0, 8'h30, 12'h000);
    @(posedge clk); @(negedge clk);
    chk("post_clr_owner", {30'd0, bus.owner}, {30'd0, OWN_CPU});
    @(posedge clk); @(negedge clk);
    chk("post_clr_rdata", {20'd0, bus.cpu_rdata}, 32'h000);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_clr_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

`ifdef MEM_ARB_LOCK_EN
    // Lock: loader takes three ties in a row, CPU returns after release
    pulse_clr();
    bus.ldr_lock = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 8'h10, 12'h000);
    set_req(1'b1, 1'b1, 1'b0, 8'hFF, 12'h000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("lock_owner", {30'd0, bus.owner}, {30'd0, OWN_LDR});
      chk("lock_stall", {31'd0, bus.cpu_stall}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("lock_acks", {30'd0, bus.ldr_ack, bus.cpu_ack}, 32'd2);
      bus.ldr_req = 1'b0;
      if (k == 2) bus.ldr_lock = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("lock_gap_stall", {31'd0, bus.cpu_stall}, 32'd1);
      bus.ldr_req = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk("unlock_owner", {30'd0, bus.owner}, {30'd0, OWN_CPU});
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("unlock_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
`endif

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
